spdif_rx_decoder: RTL and testbench
===================================

# spdif_rx_decoder

Biphase-mark S/PDIF subframe decoder that sits directly downstream of the S/PDIF transmitter. It consumes the transmitter's serial bitstream on the same 6.144 MHz clock, one sample per half-cell, and recovers left/right 24-bit samples, block boundaries and error flags. It is used in on-chip loopback for self-test and as a monitor on the outgoing audio path. It performs no clock recovery: `serialin` must be synchronous to `clk`.

## Interface
- No parameters.
- `clk` in 1 — 6.144 MHz half-cell clock, same clock as the transmitter.
- `reset_n` in 1 — asynchronous, active-low reset.
- `serialin` in 1 — S/PDIF bitstream, one half-cell per `clk`.
- `ldataout` out [0:23] — left sample; index 0 is the first bit received.
- `rdataout` out [0:23] — right sample; same ordering.
- `datavalid` out 1 — one-cycle pulse when a new L/R pair is valid on `ldataout`/`rdataout`.
- `blockstart` out 1 — high together with `datavalid` when the pair's left subframe carried preamble B.
- `lparerr`, `rparerr` out 1 — parity failure flags for the pair; held until the next `datavalid`.
- `locked` out 1 — high while framing is tracked.
- `codeerr` out 1 — one-cycle pulse on any biphase or preamble violation.
- `cstatus` out [0:191] — channel-status block; see Configuration.
- `cstatvalid` out 1 — one-cycle pulse when `cstatus` updates.

## Operation
Input and window:
- `serialin` is registered once into `s0`.
- An 8-deep history window of `s0` is kept.

Preamble match:
- The window matches a preamble when it equals one of these patterns, or its bitwise inverse: B=11101000, M=11100010, W=11100100.
- The sample preceding the window must differ from the window's first bit.
- Three equal consecutive half-cells never occur in valid data, so a match is unambiguous.

FSM:
- **HUNT**: on a B or M match, enter DATA for the left subframe. W is ignored. `locked`=0.
- **DATA**: 56 half-cells are collected as 28 cell pairs (h1,h2).
  - Violation: h1 equals the previous half-cell. This raises `codeerr`, clears `locked` and returns to HUNT, discarding the partial frame.
  - Bit value is h1^h2. Bits 0–23 are audio, bit 24 is V, 25 is U, 26 is C, 27 is P.
  - Parity passes when the XOR of all 28 bits is 0.
- **PRE**: 8 half-cells are collected, then the window is checked.
  - After a left subframe the window must match W.
  - After a right subframe it must match B or M.
  - A mismatch raises `codeerr`, clears `locked` and returns to HUNT.
  - A match enters DATA for the expected channel.

Frame completion:
- Completing a right subframe without violation makes the frame complete.
- The audio words and parity flags are loaded and `datavalid` pulses.
- `blockstart` is high if that frame's left preamble was B.
- `locked` sets on the first complete frame after HUNT.
- Parity errors set the flags only. They do not affect `locked` or `datavalid`.

Block counter:
- `framecnt` (8 bits) is cleared to 0 on a B frame and incremented on each M frame.
- An M arriving when `framecnt`==191, or a B arriving when `framecnt`!=191 while locked, pulses `codeerr` but keeps lock.

## Timing
- Reset values:
  - Every output is 0, including `cstatus`.
  - FSM is in HUNT, `framecnt`=0 and the window is cleared.
- Latency: `datavalid` is high in the cycle starting 2 edges after the edge at which `serialin` presents the final half-cell of the right subframe.
- Throughput: a locked input gives exactly one `datavalid` every 128 clocks.
- `codeerr` pulses 2 edges after the offending half-cell is presented.
- `ldataout`, `rdataout`, `lparerr`, `rparerr` and `blockstart` change only on the `datavalid` cycle. `blockstart` is otherwise 0.
- Reset asserted mid-frame: immediate return to reset values; no partial output is ever emitted.
- Simultaneous frame completion and block-sequence error: `datavalid` and `codeerr` pulse in the same cycle.

## Configuration
- `SPDIF_RX_CSTAT_EN` defined:
  - The C bit of each left subframe is shifted into a 192-bit accumulator at index `framecnt`.
  - On completion of frame 191 (locked, no violation in that block), the accumulator is copied to `cstatus` and `cstatvalid` pulses together with that frame's `datavalid`.
  - Loss of lock discards the partial block.
- Undefined: `cstatus` is tied to 0, `cstatvalid` to 0, and no accumulator is built.

## Test plan
- Loopback from the transmitter, L=0x800001, R=0x7FFFFF constant: `locked` rises after the first full frame; `datavalid` every 128 clocks with matching data; parity flags and `codeerr` stay 0.
- Long loopback run (400 frames): `blockstart` is seen exactly every 192nd `datavalid`, with no `codeerr`.
- Behavioural encoder forces a wrong P bit on the right subframe only: `rparerr`=1 and `lparerr`=0 on that `datavalid`; `locked` stays 1; next good frame clears `rparerr`.
- Force `serialin` low for 20 cycles mid-left-subframe: `codeerr` pulses, `locked` goes 0, no `datavalid` for that frame. After release, relock happens on the next B/M frame, with `datavalid` one full frame later.
- Pulse `reset_n` low for 3 cycles mid-right-subframe: all outputs read 0 immediately; relock and correct data follow without spurious `datavalid`.
- With `SPDIF_RX_CSTAT_EN`, encoder drives C=1 on left frames 0–7 and C=0 elsewhere: after frame 191, `cstatvalid` pulses and `cstatus[0:7]` is all ones with the rest zero. Without the macro, `cstatvalid` stays 0.

Source files
------------

// File: rtl/spdif_rx_decoder.sv
// Biphase-mark S/PDIF subframe decoder: recovers L/R 24-bit samples, block start and error flags.
// Optional channel-status capture is built when SPDIF_RX_CSTAT_EN is defined.
module spdif_rx_decoder (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        serialin,
  output logic [0:23] ldataout,
  output logic [0:23] rdataout,
  output logic        datavalid,
  output logic        blockstart,
  output logic        lparerr,
  output logic        rparerr,
  output logic        locked,
  output logic        codeerr,
  output logic [0:191] cstatus,
  output logic        cstatvalid
);

  localparam logic [7:0] PRE_B = 8'b11101000;
  localparam logic [7:0] PRE_M = 8'b11100010;
  localparam logic [7:0] PRE_W = 8'b11100100;

  typedef enum logic [1:0] {HUNT = 2'd0, DATA = 2'd1, PRE = 2'd2} state_t;

  state_t      state_reg, state_next;
  logic        s0_reg;
  logic [7:0]  win_reg;
  logic [5:0]  cnt_reg, cnt_next;
  logic        right_reg, right_next;
  logic        lb_reg, lb_next;
  logic [26:0] sh_reg;
  logic [23:0] lsamp_reg;
  logic        lpe_reg;
  logic [7:0]  framecnt_reg;

  logic [7:0]  cur;
  logic        edge_ok, is_b, is_m, is_w;
  logic        bitv, viol, sub_done, frame_done, seq_err, pre_fail, lose;
  logic [27:0] word;
  logic [7:0]  idx;

  function automatic logic pmatch(input logic [7:0] w, input logic [7:0] p);
    return (w == p) || (w == ~p);
  endfunction

  // cur is the 8 newest half-cells, oldest in bit 7; win_reg[7] is the one before them
  always_comb begin
    cur        = {win_reg[6:0], s0_reg};
    edge_ok    = win_reg[7] ^ cur[7];
    is_b       = edge_ok && pmatch(cur, PRE_B);
    is_m       = edge_ok && pmatch(cur, PRE_M);
    is_w       = edge_ok && pmatch(cur, PRE_W);
    bitv       = win_reg[0] ^ s0_reg;
    word       = {sh_reg, bitv};
    viol       = (state_reg == DATA) && !cnt_reg[0] && (s0_reg == win_reg[0]);
    sub_done   = (state_reg == DATA) && (cnt_reg == 6'd55);
    frame_done = sub_done && right_reg;
    idx        = lb_reg ? 8'd0 : framecnt_reg + 8'd1;
    seq_err    = frame_done && locked &&
                 (lb_reg ? (framecnt_reg != 8'd191) : (framecnt_reg == 8'd191));
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 6'd1;
    right_next = right_reg;
    lb_next    = lb_reg;
    pre_fail   = 1'b0;
    case (state_reg)
      HUNT: begin
        cnt_next = '0;
        if (is_b || is_m) begin
          state_next = DATA;
          right_next = 1'b0;
          lb_next    = is_b;
        end
      end
      DATA: begin
        if (viol) begin
          state_next = HUNT;
          cnt_next   = '0;
        end else if (sub_done) begin
          state_next = PRE;
          cnt_next   = '0;
        end
      end
      PRE: begin
        if (cnt_reg == 6'd7) begin
          cnt_next = '0;
          if (!right_reg && is_w) begin
            state_next = DATA;
            right_next = 1'b1;
          end else if (right_reg && (is_b || is_m)) begin
            state_next = DATA;
            right_next = 1'b0;
            lb_next    = is_b;
          end else begin
            state_next = HUNT;
            pre_fail   = 1'b1;
          end
        end
      end
      default: begin
        state_next = HUNT;
        cnt_next   = '0;
      end
    endcase
    lose = viol || pre_fail;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s0_reg       <= 1'b0;
      win_reg      <= '0;
      state_reg    <= HUNT;
      cnt_reg      <= '0;
      right_reg    <= 1'b0;
      lb_reg       <= 1'b0;
      sh_reg       <= '0;
      lsamp_reg    <= '0;
      lpe_reg      <= 1'b0;
      framecnt_reg <= '0;
      ldataout     <= '0;
      rdataout     <= '0;
      datavalid    <= 1'b0;
      blockstart   <= 1'b0;
      lparerr      <= 1'b0;
      rparerr      <= 1'b0;
      locked       <= 1'b0;
      codeerr      <= 1'b0;
    end else begin
      s0_reg     <= serialin;
      win_reg    <= cur;
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      right_reg  <= right_next;
      lb_reg     <= lb_next;
      datavalid  <= frame_done;
      blockstart <= frame_done && lb_reg;
      codeerr    <= lose || seq_err;
      if (state_reg == DATA && cnt_reg[0])
        sh_reg <= word[26:0];
      if (lose)
        locked <= 1'b0;
      else if (frame_done)
        locked <= 1'b1;
      if (sub_done && !right_reg) begin
        lsamp_reg <= word[27:4];
        lpe_reg   <= ^word;
      end
      // the pair is only published once the right subframe closes cleanly
      if (frame_done) begin
        ldataout     <= lsamp_reg;
        rdataout     <= word[27:4];
        lparerr      <= lpe_reg;
        rparerr      <= ^word;
        framecnt_reg <= idx;
      end
    end
  end

`ifdef SPDIF_RX_CSTAT_EN
  logic [0:191] acc_reg, acc_upd;
  logic         lc_reg, block_ok_reg;

  always_comb begin
    acc_upd = acc_reg;
    if (idx < 8'd192)
      acc_upd[idx] = lc_reg;
  end

  // block_ok_reg tracks an unbroken run of frames since the last B
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_reg      <= '0;
      lc_reg       <= 1'b0;
      block_ok_reg <= 1'b0;
      cstatus      <= '0;
      cstatvalid   <= 1'b0;
    end else begin
      cstatvalid <= 1'b0;
      if (sub_done && !right_reg)
        lc_reg <= word[1];
      if (lose) begin
        block_ok_reg <= 1'b0;
      end else if (frame_done) begin
        acc_reg <= acc_upd;
        if (lb_reg)
          block_ok_reg <= 1'b1;
        else if (seq_err)
          block_ok_reg <= 1'b0;
        if (idx == 8'd191 && block_ok_reg && locked) begin
          cstatus    <= acc_upd;
          cstatvalid <= 1'b1;
        end
      end
    end
  end
`else
  assign cstatus    = '0;
  assign cstatvalid = 1'b0;
`endif

endmodule

// File: tb/tb_spdif_rx_decoder.sv
// Directed bench for spdif_rx_decoder: behavioural biphase encoder feeds frames, a queue of
// expected pairs is checked on every datavalid.
module tb_spdif_rx_decoder;

  localparam logic [7:0]   PRE_B   = 8'b11101000;
  localparam logic [7:0]   PRE_M   = 8'b11100010;
  localparam logic [7:0]   PRE_W   = 8'b11100100;
  localparam logic [191:0] CS_ONES = {8'hFF, 184'd0};

  logic        clk = 1'b0;
  logic        reset_n;
  logic        serialin;
  logic [0:23] ldataout, rdataout;
  logic        datavalid, blockstart, lparerr, rparerr, locked, codeerr, cstatvalid;
  logic [0:191] cstatus;

  typedef struct {
    logic [0:23] l;
    logic [0:23] r;
    logic        lpe, rpe, bs, ce, cs;
    int          endc;
  } exp_t;

  exp_t exp_q[$];
  exp_t m;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   cerr_cnt = 0;
  int   blk = 0;
  logic lvl;
  logic hc [0:127];

  spdif_rx_decoder dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .serialin   (serialin),
    .ldataout   (ldataout),
    .rdataout   (rdataout),
    .datavalid  (datavalid),
    .blockstart (blockstart),
    .lparerr    (lparerr),
    .rparerr    (rparerr),
    .locked     (locked),
    .codeerr    (codeerr),
    .cstatus    (cstatus),
    .cstatvalid (cstatvalid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Encode one subframe (preamble + 28 biphase cells) into hc[base +: 64]
  task automatic enc_sub(input logic [7:0] pat, input logic [0:23] a, input logic c,
                         input logic bad, input int base);
    logic [0:27] d;
    logic        inv;
    d     = {a, 1'b0, 1'b0, c, 1'b0};
    d[27] = (^d[0:26]) ^ bad;
    inv   = lvl;
    for (int k = 0; k < 8; k++) hc[base + k] = pat[7 - k] ^ inv;
    lvl = hc[base + 7];
    for (int k = 0; k < 28; k++) begin
      lvl = ~lvl;
      hc[base + 8 + 2 * k] = lvl;
      if (d[k]) lvl = ~lvl;
      hc[base + 9 + 2 * k] = lvl;
    end
  endtask

  task automatic send_frame(input logic [0:23] l, input logic [0:23] r, input bit isb,
                            input bit c, input bit lbad, input bit rbad, input int kill_at,
                            input int rst_at, input bit push, input bit ce, input bit cs);
    exp_t e;
    enc_sub(isb ? PRE_B : PRE_M, l, c, lbad, 0);
    enc_sub(PRE_W, r, 1'b0, rbad, 64);
    for (int i = 0; i < 128; i++) begin
      @(posedge clk);
      #1;
      serialin = (i >= kill_at && i < kill_at + 20) ? 1'b0 : hc[i];
      if (kill_at >= 0 && i == kill_at + 20)
        chk("locked_after_kill", 192'(locked), 192'(0));
      if (i == rst_at) begin
        reset_n = 1'b0;
        #1;
        chk("midframe_reset_outputs", 192'({ldataout, rdataout, datavalid, blockstart, lparerr,
            rparerr, locked, codeerr, cstatvalid}), 192'(0));
        chk("midframe_reset_cstatus", 192'(cstatus), 192'(0));
      end
      if (rst_at >= 0 && i == rst_at + 3) reset_n = 1'b1;
    end
    if (push) begin
      e.l = l; e.r = r; e.lpe = lbad; e.rpe = rbad; e.bs = isb; e.ce = ce; e.cs = cs;
      e.endc = cyc;
      exp_q.push_back(e);
    end
  endtask

  task automatic good_frame(input logic [0:23] l, input logic [0:23] r, input bit lbad,
                            input bit rbad, input bit ce);
    bit isb, c, cs;
    isb = (blk == 0);
    c   = (blk < 8);
`ifdef SPDIF_RX_CSTAT_EN
    cs  = (blk == 191);
`else
    cs  = 1'b0;
`endif
    send_frame(l, r, isb, c, lbad, rbad, -100, -100, 1'b1, ce, cs);
    blk = (blk == 191) ? 0 : blk + 1;
  endtask

  always @(negedge clk) begin
    if (codeerr) cerr_cnt++;
    if (datavalid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_datavalid", 192'(datavalid), 192'(0));
      end else begin
        m = exp_q.pop_front();
        $display("pair L=%h R=%h lpe=%0b rpe=%0b bs=%0b ce=%0b cs=%0b", ldataout, rdataout,
                 lparerr, rparerr, blockstart, codeerr, cstatvalid);
        chk("ldataout", 192'(ldataout), 192'(m.l));
        chk("rdataout", 192'(rdataout), 192'(m.r));
        chk("lparerr", 192'(lparerr), 192'(m.lpe));
        chk("rparerr", 192'(rparerr), 192'(m.rpe));
        chk("blockstart", 192'(blockstart), 192'(m.bs));
        chk("codeerr_at_dv", 192'(codeerr), 192'(m.ce));
        chk("locked_at_dv", 192'(locked), 192'(1));
        chk("dv_latency", 192'(cyc - m.endc), 192'(2));
        chk("cstatvalid", 192'(cstatvalid), 192'(m.cs));
`ifdef SPDIF_RX_CSTAT_EN
        if (m.cs) chk("cstatus", 192'(cstatus), CS_ONES);
`else
        chk("cstatus_tied", 192'(cstatus), 192'(0));
`endif
      end
    end
  end

  initial begin
    logic [0:23] l, r;
    reset_n  = 1'b0;
    serialin = 1'b0;
    lvl      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 192'({ldataout, rdataout, datavalid, blockstart, lparerr, rparerr,
        locked, codeerr, cstatvalid}), 192'(0));
    chk("reset_cstatus", 192'(cstatus), 192'(0));
    reset_n = 1'b1;
    repeat (4) @(posedge clk);

    // long locked run: two full blocks plus a partial one, a few parity faults inside
    for (int f = 0; f < 400; f++) begin
      if (f >= 8 && f < 24) begin
        l = 24'($urandom());
        r = 24'($urandom());
      end else begin
        l = 24'h800001;
        r = 24'h7FFFFF;
      end
      good_frame(l, r, f == 12, f == 3 || f == 10, 1'b0);
      if (f == 0) chk("locked_before_first_dv", 192'(locked), 192'(0));
    end
    chk("codeerr_count_clean", 192'(cerr_cnt), 192'(0));
    chk("locked_steady", 192'(locked), 192'(1));

    // serialin held low mid left subframe, then relock on a fresh B frame
    send_frame(24'h123456, 24'h654321, blk == 0, blk < 8, 1'b0, 1'b0, 20, -100, 1'b0, 1'b0, 1'b0);
    chk("codeerr_count_kill", 192'(cerr_cnt), 192'(1));
    blk = 0;
    for (int f = 0; f < 3; f++) good_frame(24'($urandom()), 24'($urandom()), 1'b0, 1'b0, 1'b0);

    // reset pulse inside the right subframe
    send_frame(24'hABCDEF, 24'h0F0F0F, blk == 0, blk < 8, 1'b0, 1'b0, -100, 80, 1'b0, 1'b0, 1'b0);
    blk = 0;
    for (int f = 0; f < 3; f++) good_frame(24'($urandom()), 24'($urandom()), 1'b0, 1'b0, 1'b0);

    // early B while locked: datavalid and codeerr together, lock kept
    blk = 0;
    good_frame(24'h800001, 24'h7FFFFF, 1'b0, 1'b0, 1'b1);
    for (int f = 0; f < 2; f++) good_frame(24'h800001, 24'h7FFFFF, 1'b0, 1'b0, 1'b0);

    repeat (8) @(posedge clk);
    #1;
    chk("queue_drained", 192'(exp_q.size()), 192'(0));
    chk("codeerr_count_final", 192'(cerr_cnt), 192'(2));
    chk("locked_final", 192'(locked), 192'(1));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
